// File: rtl/pio_pkg.sv
// pio_pkg
//   Shared definitions for the input PIO: register word addresses and the
//   encodings of the EDGE_TYPE parameter.
//   No ports (package).
package pio_pkg;

  // Register word addresses on the Avalon-MM slave.
  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_IRQMASK = 2'd1,
    ADDR_RSVD    = 2'd2,
    ADDR_EDGECAP = 2'd3
  } pio_addr_e;

  // EDGE_TYPE encodings.
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pio_debounce_bit.sv
// pio_debounce_bit
//   One input pin: 2-flop synchronizer followed by a debouncer. A new level
//   on the synchronized input must persist for DEBOUNCE_CYCLES consecutive
//   sampled cycles before it is accepted onto dout; any cycle where the
//   synchronized input matches dout restarts the count.
// Ports:
//   clk     - system clock
//   reset_n - asynchronous active-low reset
//   din     - raw asynchronous pin
//   dout    - debounced level
module pio_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  logic             s1;
  logic             s2;
  logic             db;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      db  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // Terminal count: accept the new level. The counter never wraps.
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign dout = db;

endmodule

// File: rtl/pio_in_edge_irq.sv
// pio_in_edge_irq
//   Avalon-MM slave input PIO with per-pin synchronizer/debouncer, edge
//   detection, sticky write-1-to-clear edge capture and a masked level IRQ.
//   Register map (word address, unused upper bits read 0):
//     0 DATA        read-only debounced pin levels
//     1 IRQMASK     read/write
//     2 reserved    reads 0, writes ignored
//     3 EDGECAPTURE read captured edges, write 1 to clear a bit
// Bus protocol: zero-wait-state slave. A write is taken on any clock edge
//   where chipselect=1 and write_n=0. Reads have latency 0: readdata is a
//   purely combinational decode of address and has no side effects, so
//   there is no valid/ready handshake to track.
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata    - Avalon-MM slave write/select inputs
//   in_port               - raw asynchronous pin inputs
//   readdata              - read data, combinational from address
//   irq                   - active-high level interrupt
module pio_in_edge_irq
  import pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = EDGE_RISING,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] db_prev;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (in_port[i]),
      .dout   (db[i])
    );
  end

  assign wr_en = chipselect & ~write_n;

  // Bits of writedata above WIDTH have no register behind them.
  assign unused_wdata = ^(writedata >> WIDTH);

  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      EDGE_FALLING: edge_det = ~db & db_prev;
      EDGE_ANY:     edge_det = db ^ db_prev;
      default:      edge_det = db & ~db_prev;
    endcase
  end

  assign clr = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_prev     <= '0;
      irqmask     <= '0;
      edgecapture <= '0;
    end else begin
      db_prev <= db;
      if (wr_en && address == ADDR_IRQMASK) begin
        irqmask <= writedata[WIDTH-1:0];
      end
      // A new edge wins over a clear landing in the same cycle.
      edgecapture <= edge_det | (edgecapture & ~clr);
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata = 32'(db);
      ADDR_IRQMASK: readdata = 32'(irqmask);
      ADDR_EDGECAP: readdata = 32'(edgecapture);
      default:      readdata = '0;
    endcase
  end

  assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// tb_pio_in_edge_irq
//   Two instances share every input: u_rise (EDGE_TYPE=0) and u_any
//   (EDGE_TYPE=2). A reference model kept here tracks pin history as a
//   window of samples and derives debounced levels, edges, capture and irq.
module tb_pio_in_edge_irq;
  localparam int W = 4;
  localparam int D = 4;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   address = 2'd0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic [31:0]  writedata = 32'd0;
  logic [W-1:0] in_port = '0;
  logic [31:0]  rd_r, rd_a;
  logic         irq_r, irq_a;

  always #5 clk = ~clk;

  pio_in_edge_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_r), .irq(irq_r)
  );

  pio_in_edge_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_a), .irq(irq_a)
  );

  // ---------------- scoreboard / model ----------------
  int n_tests = 0;
  int n_fail  = 0;

  // samp_q holds the last D+2 values of in_port seen at clock edges; the
  // oldest D of them are the synchronized samples that decide acceptance.
  logic [W-1:0] samp_q[$];
  logic [W-1:0] m_db, m_dbp, m_mask;
  logic [W-1:0] m_cap [2];
  int           m_et  [2] = '{0, 2};

  function automatic logic [W-1:0] edges_of(int et, logic [W-1:0] cur, logic [W-1:0] prev);
    if (et == 2) return cur ^ prev;
    if (et == 1) return ~cur & prev;
    return cur & ~prev;
  endfunction

  task automatic model_reset();
    samp_q = {};
    repeat (D + 2) samp_q.push_back('0);
    m_db = '0; m_dbp = '0; m_mask = '0;
    m_cap[0] = '0; m_cap[1] = '0;
  endtask

  task automatic model_edge();
    logic [W-1:0] nxt_db;
    logic [W-1:0] clr;
    logic         wr;
    logic         same;
    samp_q.push_back(in_port);
    void'(samp_q.pop_front());
    nxt_db = m_db;
    for (int b = 0; b < W; b++) begin
      same = 1'b1;
      for (int j = 1; j < D; j++) if (samp_q[j][b] !== samp_q[0][b]) same = 1'b0;
      if (same && samp_q[0][b] !== m_db[b]) nxt_db[b] = samp_q[0][b];
    end
    wr  = chipselect && !write_n;
    clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
    for (int k = 0; k < 2; k++)
      m_cap[k] = edges_of(m_et[k], m_db, m_dbp) | (m_cap[k] & ~clr);
    if (wr && address == 2'd1) m_mask = writedata[W-1:0];
    m_dbp = m_db;
    m_db  = nxt_db;
  endtask

  function automatic logic [31:0] exp_rd(int k);
    case (address)
      2'd0:    return 32'(m_db);
      2'd1:    return 32'(m_mask);
      2'd3:    return 32'(m_cap[k]);
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s addr=%0d got=%h exp=%h", tag, address, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_rd_rise"}, rd_r, exp_rd(0));
    check({tag, "_rd_any"},  rd_a, exp_rd(1));
    check({tag, "_irq_rise"}, 32'(irq_r), 32'(|(m_cap[0] & m_mask)));
    check({tag, "_irq_any"},  32'(irq_a), 32'(|(m_cap[1] & m_mask)));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set_addr(input logic [1:0] a);
    address = a;
    #1;
    check_all("addr");
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    tick("wr");
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] seen;

  initial begin
    // Reset state
    model_reset();
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      check("rst_rd_rise", rd_r, 32'd0);
      check("rst_rd_any", rd_a, 32'd0);
      check("rst_irq", 32'(irq_r | irq_a), 32'd0);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) tick("idle");

    // Rising pin 0: DATA at the 6th edge counting the first sampling edge
    set_addr(2'd0);
    in_port = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      tick("lat");
      check("data_lat", rd_r, (i == 5) ? 32'h1 : 32'h0);
    end
    set_addr(2'd3);
    check("cap_before", rd_r, 32'h0);
    tick("cap");
    check("cap_set", rd_r, 32'h1);
    check("irq_masked", 32'(irq_r), 32'd0);

    // Mask / clear behaviour
    wr_reg(2'd1, 32'h1);
    check("irq_unmask", 32'(irq_r), 32'd1);
    wr_reg(2'd3, 32'h0);
    set_addr(2'd3);
    check("clr0_keeps", rd_r, 32'h1);
    wr_reg(2'd3, 32'h1);
    set_addr(2'd3);
    check("clr1_clears", rd_r, 32'h0);
    check("irq_cleared", 32'(irq_r), 32'd0);

    // Glitch shorter than the window never reaches DATA
    set_addr(2'd0);
    seen = '0;
    in_port = 4'b0101;
    repeat (3) begin tick("glitch"); seen |= rd_r; end
    in_port = 4'b0001;
    repeat (10) begin tick("glitch"); seen |= rd_r; end
    check("glitch3_rejected", seen & 32'h4, 32'h0);
    in_port = 4'b0101;
    repeat (4) begin tick("pulse"); seen |= rd_r; end
    in_port = 4'b0001;
    repeat (12) begin tick("pulse"); seen |= rd_r; end
    check("pulse4_accepted", seen & 32'h4, 32'h4);

    // Clear in the same cycle as a captured rising edge on bit 1
    wr_reg(2'd3, 32'hF);
    in_port = 4'b0011;
    repeat (6) tick("setwin");
    wr_reg(2'd3, 32'h2);
    set_addr(2'd3);
    check("set_wins_rise", rd_r & 32'h2, 32'h2);
    check("set_wins_any", rd_a & 32'h2, 32'h2);
    wr_reg(2'd3, 32'hF);

    // Any-edge capture on bit 3
    in_port = 4'b1011;
    repeat (12) tick("up");
    set_addr(2'd3);
    check("any_up", rd_a & 32'h8, 32'h8);
    wr_reg(2'd3, 32'hF);
    in_port = 4'b0011;
    repeat (12) tick("down");
    set_addr(2'd3);
    check("any_down", rd_a & 32'h8, 32'h8);
    check("rise_no_fall", rd_r & 32'h8, 32'h0);

    // Asynchronous reset in the middle of a debounce window
    wr_reg(2'd1, 32'hF);
    in_port = 4'b1111;
    repeat (3) tick("predb");
    reset_n = 1'b0;
    #1;
    model_reset();
    for (int a = 0; a < 4; a++) set_addr(2'(a));
    check("rst_async_irq", 32'(irq_r | irq_a), 32'd0);
    repeat (2) begin @(posedge clk); #1; check_all("in_rst"); end
    reset_n = 1'b1;
    set_addr(2'd0);
    for (int i = 0; i < 6; i++) begin
      tick("postrst");
      check("data_postrst", rd_r, (i == 5) ? 32'hF : 32'h0);
    end
    tick("postrst");

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 5) == 0) in_port = W'($urandom_range(0, 15));
      else if ($urandom_range(0, 3) == 0) in_port[$urandom_range(0, W - 1)] ^= 1'b1;
      address = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) begin
        chipselect = 1'b1; write_n = 1'b0; writedata = $urandom;
      end else begin
        chipselect = 1'($urandom_range(0, 1)); write_n = 1'b1; writedata = $urandom;
      end
      tick("rand");
    end
    chipselect = 1'b0; write_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
